key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 156 +++++++++++++++
 tb/tb_key_debounce.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Four-key debouncer: each raw active-low key is synchronized, debounced and
// turned into a debounced level plus press, release and long-hold pulses.
module key_debounce #(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_long
);

  localparam int NUM_KEYS = 4;

  // Keys share nothing but the clock and reset, so there is no priority between them.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_lane #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_lane (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_n    (key[i]),
      .state_o  (key_state[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i])
    );
  end

endmodule

// One key: 2-flop synchronizer feeding a debounce FSM with registered outputs.
module key_debounce_lane #(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_n,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_e;

  localparam logic [25:0] DEB_LAST = 26'(DEB_CYCLES - 1);
  localparam logic [25:0] LONG_LIM = 26'(LONG_CYCLES);

  logic        sync1_q, sync1_d;
  logic        ks_q, ks_d;
  state_e      st_q, st_d;
  logic [25:0] deb_cnt_q, deb_cnt_d;
  logic [25:0] hold_cnt_q, hold_cnt_d;
  logic        state_q, state_d;
  logic        press_q, press_d;
  logic        rel_q, rel_d;
  logic        long_q, long_d;

  always_comb begin
    sync1_d    = key_n;
    ks_d       = sync1_q;
    st_d       = st_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    state_d    = state_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    long_d     = 1'b0;

    // Hold time keeps running through a release bounce; it saturates so the
    // long pulse can fire only once per press.
    if ((st_q == HELD || st_q == REL_DEB) && hold_cnt_q < LONG_LIM) begin
      hold_cnt_d = hold_cnt_q + 26'd1;
      if (hold_cnt_q == LONG_LIM - 26'd1) long_d = 1'b1;
    end

    case (st_q)
      IDLE: begin
        if (!ks_q) begin
          st_d      = PRESS_DEB;
          deb_cnt_d = '0;
        end
      end
      PRESS_DEB: begin
        if (ks_q) begin
          st_d      = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          st_d       = HELD;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          state_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 26'd1;
        end
      end
      HELD: begin
        if (ks_q) begin
          st_d      = REL_DEB;
          deb_cnt_d = '0;
        end
      end
      REL_DEB: begin
        if (!ks_q) begin
          st_d      = HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          st_d      = IDLE;
          deb_cnt_d = '0;
          state_d   = 1'b0;
          rel_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 26'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q    <= 1'b1;
      ks_q       <= 1'b1;
      st_q       <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      ks_q       <= ks_d;
      st_q       <= st_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts every
// cycle's outputs; a negedge monitor compares; directed timing checks ride alongside.
module tb_key_debounce;

  localparam int DEB  = 8;
  localparam int LONG = 32;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] key     = 4'hF;
  logic [3:0] key_state, key_press, key_release, key_long;

  key_debounce #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   press_cnt[4] = '{0, 0, 0, 0};
  int   rel_cnt[4]   = '{0, 0, 0, 0};
  int   long_cnt[4]  = '{0, 0, 0, 0};

  // Reference model: debounced level flips once the synchronized key has
  // disagreed with it for DEB+1 consecutive edges; long fires LONG edges after press.
  bit m_pressed[4];
  int m_run[4];
  int m_since[4];
  bit m_s1[4];
  bit m_s2[4];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] k, input logic r);
    exp_t e;
    bit   ks;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_pressed[i] = 1'b0;
        m_run[i]     = 0;
        m_since[i]   = 0;
        m_s1[i]      = 1'b1;
        m_s2[i]      = 1'b1;
      end else begin
        ks = m_s2[i];
        if (m_pressed[i] && m_since[i] < LONG) begin
          m_since[i]++;
          if (m_since[i] == LONG) e.lg[i] = 1'b1;
        end
        if (ks == m_pressed[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB + 1) begin
          m_run[i]     = 0;
          m_pressed[i] = !m_pressed[i];
          if (m_pressed[i]) begin
            e.pr[i]    = 1'b1;
            m_since[i] = 0;
          end else begin
            e.rl[i] = 1'b1;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = k[i];
      end
      e.st[i] = m_pressed[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] k, input logic r);
    @(negedge sys_clk);
    key     = k;
    sys_rst = r;
    @(posedge sys_clk);
    model_edge(k, r);
  endtask

  task automatic settle();
    @(negedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_state", key_state, e.st);
      chk("sb_press", key_press, e.pr);
      chk("sb_release", key_release, e.rl);
      chk("sb_long", key_long, e.lg);
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] += int'(key_press[i]);
        rel_cnt[i]   += int'(key_release[i]);
        long_cnt[i]  += int'(key_long[i]);
      end
    end
  end

  initial begin
    int p0[4], r0[4], l0[4];
    logic [3:0] cur;
    int left[4];

    for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
    #1 chk("reset_outputs", key_state | key_press | key_release | key_long, 4'h0);

    // Clean press on key 0 with long hold
    for (int i = 0; i < 4; i++) begin p0[i] = press_cnt[i]; r0[i] = rel_cnt[i]; l0[i] = long_cnt[i]; end
    for (int j = 0; j < 100; j++) begin
      step(4'b1110, 1'b0);
      if (j == 9)  begin #1; chk("clean_no_early", key_state, 4'b0000); end
      if (j == 10) begin #1; chk("clean_press", key_press, 4'b0001); chk("clean_state", key_state, 4'b0001); end
      if (j == 41) begin #1; chk("clean_no_early_long", key_long, 4'b0000); end
      if (j == 42) begin #1; chk("clean_long", key_long, 4'b0001); end
    end
    for (int j = 0; j < 20; j++) begin
      step(4'hF, 1'b0);
      if (j == 9)  begin #1; chk("clean_rel_early", key_release, 4'b0000); end
      if (j == 10) begin #1; chk("clean_release", key_release, 4'b0001); chk("clean_state_off", key_state, 4'b0000); end
    end
    settle();
    chk_int("clean_press_cnt", press_cnt[0] - p0[0], 1);
    chk_int("clean_long_cnt", long_cnt[0] - l0[0], 1);
    chk_int("clean_rel_cnt", rel_cnt[0] - r0[0], 1);
    chk_int("clean_others", press_cnt[1] + press_cnt[2] + press_cnt[3] - p0[1] - p0[2] - p0[3], 0);

    // Press bounce on key 1
    for (int i = 0; i < 4; i++) begin p0[i] = press_cnt[i]; r0[i] = rel_cnt[i]; end
    for (int j = 0; j < 5; j++)  step(4'b1101, 1'b0);
    for (int j = 0; j < 2; j++)  step(4'hF, 1'b0);
    for (int j = 0; j < 5; j++)  step(4'b1101, 1'b0);
    for (int j = 0; j < 15; j++) step(4'hF, 1'b0);
    settle();
    chk("bounce_state", key_state, 4'b0000);
    chk_int("bounce_no_press", press_cnt[1] - p0[1], 0);
    chk_int("bounce_no_release", rel_cnt[1] - r0[1], 0);
    for (int j = 0; j < 20; j++) step(4'b1101, 1'b0);
    for (int j = 0; j < 20; j++) step(4'hF, 1'b0);
    settle();
    chk_int("bounce_one_press", press_cnt[1] - p0[1], 1);

    // Release glitch on key 2
    for (int i = 0; i < 4; i++) begin r0[i] = rel_cnt[i]; l0[i] = long_cnt[i]; end
    for (int j = 0; j < 15; j++) step(4'b1011, 1'b0);
    for (int j = 0; j < 3; j++)  step(4'hF, 1'b0);
    for (int j = 0; j < 10; j++) step(4'b1011, 1'b0);
    settle();
    chk("glitch_state_held", key_state, 4'b0100);
    chk_int("glitch_no_release", rel_cnt[2] - r0[2], 0);
    for (int j = 0; j < 20; j++) begin
      step(4'hF, 1'b0);
      if (j == 9)  begin #1; chk("glitch_rel_early", key_release, 4'b0000); end
      if (j == 10) begin #1; chk("glitch_release", key_release, 4'b0100); end
    end
    settle();
    chk_int("glitch_no_long", long_cnt[2] - l0[2], 0);

    // Simultaneous short hold on keys 0 and 3
    for (int i = 0; i < 4; i++) begin l0[i] = long_cnt[i]; end
    for (int j = 0; j < 20; j++) begin
      step(4'b0110, 1'b0);
      if (j == 10) begin #1; chk("simul_press", key_press, 4'b1001); end
    end
    for (int j = 0; j < 20; j++) begin
      step(4'hF, 1'b0);
      if (j == 10) begin #1; chk("simul_release", key_release, 4'b1001); end
    end
    settle();
    chk_int("simul_no_long", long_cnt[0] + long_cnt[3] - l0[0] - l0[3], 0);

    // Reset mid-hold on key 0
    for (int i = 0; i < 4; i++) begin p0[i] = press_cnt[i]; r0[i] = rel_cnt[i]; end
    for (int j = 0; j < 20; j++) step(4'b1110, 1'b0);
    step(4'b1110, 1'b1);
    #1 chk("rst_outputs", key_state | key_press | key_release | key_long, 4'h0);
    for (int j = 0; j < 20; j++) begin
      step(4'b1110, 1'b0);
      if (j == 9)  begin #1; chk("rst_repress_early", key_press, 4'b0000); end
      if (j == 10) begin #1; chk("rst_repress", key_press, 4'b0001); end
    end
    for (int j = 0; j < 20; j++) step(4'hF, 1'b0);
    settle();
    chk_int("rst_press_cnt", press_cnt[0] - p0[0], 2);
    chk_int("rst_rel_cnt", rel_cnt[0] - r0[0], 1);

    // Randomized runs of mixed lengths, with occasional reset
    cur = 4'hF;
    for (int i = 0; i < 4; i++) left[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (left[i] == 0) begin
          cur[i]  = ~cur[i];
          left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 50);
        end
        left[i]--;
      end
      step(cur, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    for (int j = 0; j < 30; j++) step(4'hF, 1'b0);
    settle();
    chk_int("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
